alu_arbiter: RTL
================

# alu_arbiter

Shares the single-cycle combinational ALU between two requesters, such as a fetch/branch unit and an execute unit. It accepts one operation at a time through a valid/ready handshake and drives the ALU's operand, control and shift-amount inputs from internal registers. It captures `result`/`zero` and returns them tagged with the requester ID as a one-cycle response pulse. It sits between the requesters and the ALU instance, and is the only driver of the ALU inputs.

## Interface

Parameters:
- `WIDTH`, 32, operand/result width; the ALU is 32-bit, so only 32 is supported.
- `CNT_WIDTH`, 16, width of the completed-operation counter.

Ports:
- `clk` in 1: rising-edge clock.
- `reset` in 1: synchronous, active-high reset.
- `reqValid` in 2: bit i = requester i has an operation pending.
- `reqReady` out 2: bit i = requester i's operation is accepted this cycle.
- `reqInputOne` in 2*WIDTH: packed operand A; requester i at `[i*WIDTH +: WIDTH]`.
- `reqInputTwo` in 2*WIDTH: packed operand B, same packing.
- `reqControl` in 8: packed 4-bit ALU control per requester (0000 ADD, 0010 NOT, 0100 LSR, 0111 SLT; other codes passed through unchanged).
- `reqShiftAmount` in 10: packed 5-bit shift amount per requester.
- `aluInputOne` out WIDTH: to `ALU.inputOne`.
- `aluInputTwo` out WIDTH: to `ALU.inputTwo`.
- `aluControl` out 4: to `ALU.ALUControl`.
- `aluShiftAmount` out 5: to `ALU.shiftAmount`.
- `aluResult` in WIDTH: from `ALU.result`.
- `aluZero` in 1: from `ALU.zero`.
- `respValid` out 1: one-cycle response pulse.
- `respId` out 1: requester that owns the response.
- `respResult` out WIDTH: captured ALU result.
- `respZero` out 1: captured ALU zero flag.
- `busy` out 1: high in EXEC and RESP.
- `opCount` out CNT_WIDTH: number of completed operations.

## Operation

- FSM states: IDLE, EXEC, RESP.
  - IDLE → EXEC when any `reqValid` bit is set.
  - EXEC → RESP unconditionally.
  - RESP → IDLE unconditionally.
- Grant decision (IDLE only):
  - One valid requester: grant it.
  - Both valid: grant the requester not granted last (round-robin pointer `lastGrant`).
- `reqReady[g]` is combinational: asserted only in IDLE, only for the granted g, and never while `reset` is high. At most one bit is set.
- On the handshake (`reqValid[g] & reqReady[g]`):
  - Register g's operands, control and shift amount into the ALU-driving registers.
  - Set `lastGrant <= g` and latch g for `respId`.
  - `lastGrant` changes only on a handshake.
- EXEC: ALU inputs are held stable. At the end of the cycle, capture `aluResult` into `respResult` and `aluZero` into `respZero`.
- RESP:
  - `respValid` = 1 for exactly one cycle; no backpressure.
  - `opCount` increments by 1, wrapping from all-ones to 0.
- ALU-driving registers hold their last values in IDLE; they change only on a handshake.
- `respResult`, `respZero` and `respId` hold their values until the next capture.
- The arbiter does not decode or check opcodes.

## Timing

- Handshake in cycle T0. The ALU sees the new inputs in T1 (EXEC). `respValid` is high in T2 (RESP).
- The next handshake is possible in T3. Peak throughput is one operation per 3 cycles.
- A requester's latency from the handshake to its response is exactly 2 cycles.
- A request arriving during EXEC or RESP waits; it is accepted in the first IDLE cycle.
- A requester may deassert `reqValid` without a handshake; no operation is issued for it.
- Reset values:
  - FSM in IDLE; `lastGrant = 1`, so requester 0 wins the first tie.
  - All outputs are 0: `reqReady`, `alu*`, `resp*`, `busy`, `opCount`.
- Reset asserted mid-operation (EXEC or RESP):
  - The operation is aborted; no `respValid` pulse, even if `reset` hits in RESP.
  - `opCount` returns to 0.
  - The first IDLE handshake can occur in the cycle after `reset` deasserts.

## Configuration

- Macro `ALU_ARB_FIXED_PRIO_EN`.
  - Defined: fixed priority. Requester 0 always wins a tie; `lastGrant` is still recorded but ignored.
  - Undefined (default): round-robin as described above.

## Test plan

- Req0 only, ADD 4+8: `reqReady` = 01 at T0; T2 `respValid` = 1, `respId` = 0, `respResult` = 12, `respZero` = 0, `opCount` = 1.
- After reset, both valid in the same cycle:
  - Req0 NOT 3: granted first, `respResult` = 0xFFFFFFFC.
  - Req1 LSR 10 by 2: granted at T3, T5 `respId` = 1, `respResult` = 2.
- Req1 SLT 17,2: `respResult` = 0, `respZero` = 1.
- Both held valid for 4 operations: grants alternate 0,1,0,1; `respValid` pulses are 3 cycles apart; `opCount` = 4.
- `reset` pulsed during EXEC: no `respValid`, `opCount` = 0, `reqReady` = 00 while reset is high; then req0 is granted on a tie.
- With `ALU_ARB_FIXED_PRIO_EN` defined, both held valid for 3 operations: `respId` = 0,0,0.

Source files
------------

// File: rtl/alu_arbiter.sv
// Two-requester arbiter in front of a single-cycle ALU: IDLE -> EXEC -> RESP per operation.
// Define ALU_ARB_FIXED_PRIO_EN for fixed priority (requester 0 wins ties); default is round-robin.
module alu_arbiter #(
  parameter int WIDTH     = 32,
  parameter int CNT_WIDTH = 16
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [1:0]           reqValid,
  output logic [1:0]           reqReady,
  input  logic [2*WIDTH-1:0]   reqInputOne,
  input  logic [2*WIDTH-1:0]   reqInputTwo,
  input  logic [7:0]           reqControl,
  input  logic [9:0]           reqShiftAmount,
  output logic [WIDTH-1:0]     aluInputOne,
  output logic [WIDTH-1:0]     aluInputTwo,
  output logic [3:0]           aluControl,
  output logic [4:0]           aluShiftAmount,
  input  logic [WIDTH-1:0]     aluResult,
  input  logic                 aluZero,
  output logic                 respValid,
  output logic                 respId,
  output logic [WIDTH-1:0]     respResult,
  output logic                 respZero,
  output logic                 busy,
  output logic [CNT_WIDTH-1:0] opCount
);

  typedef enum logic [1:0] {IDLE, EXEC, RESP} state_t;

  state_t               state_q, state_d;
  logic                 lastGrant_q;
  logic                 grant;
  logic                 handshake;
  logic [WIDTH-1:0]     aluInputOne_q, aluInputTwo_q;
  logic [3:0]           aluControl_q;
  logic [4:0]           aluShiftAmount_q;
  logic                 respId_q, respZero_q;
  logic [WIDTH-1:0]     respResult_q;
  logic [CNT_WIDTH-1:0] opCount_q;

  // A lone requester always wins; a tie goes by priority mode.
  always_comb begin
    grant = 1'b0;
    if (reqValid == 2'b10) begin
      grant = 1'b1;
    end else if (reqValid == 2'b11) begin
`ifdef ALU_ARB_FIXED_PRIO_EN
      grant = 1'b0;
`else
      grant = ~lastGrant_q;
`endif
    end
  end

  always_comb begin
    reqReady = 2'b00;
    if (state_q == IDLE && !reset && reqValid[grant]) begin
      reqReady = grant ? 2'b10 : 2'b01;
    end
  end

  assign handshake = |(reqValid & reqReady);

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (|reqValid) state_d = EXEC;
      EXEC:    state_d = RESP;
      RESP:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // opCount advances as EXEC closes so the new count is visible with the response.
  always_ff @(posedge clk) begin
    if (reset) begin
      lastGrant_q      <= 1'b1;
      aluInputOne_q    <= '0;
      aluInputTwo_q    <= '0;
      aluControl_q     <= '0;
      aluShiftAmount_q <= '0;
      respId_q         <= 1'b0;
      respResult_q     <= '0;
      respZero_q       <= 1'b0;
      opCount_q        <= '0;
    end else begin
      if (handshake) begin
        lastGrant_q      <= grant;
        respId_q         <= grant;
        aluInputOne_q    <= grant ? reqInputOne[2*WIDTH-1:WIDTH] : reqInputOne[WIDTH-1:0];
        aluInputTwo_q    <= grant ? reqInputTwo[2*WIDTH-1:WIDTH] : reqInputTwo[WIDTH-1:0];
        aluControl_q     <= grant ? reqControl[7:4] : reqControl[3:0];
        aluShiftAmount_q <= grant ? reqShiftAmount[9:5] : reqShiftAmount[4:0];
      end
      if (state_q == EXEC) begin
        respResult_q <= aluResult;
        respZero_q   <= aluZero;
        opCount_q    <= opCount_q + 1'b1;
      end
    end
  end

  assign aluInputOne    = aluInputOne_q;
  assign aluInputTwo    = aluInputTwo_q;
  assign aluControl     = aluControl_q;
  assign aluShiftAmount = aluShiftAmount_q;
  assign respValid      = (state_q == RESP) && !reset;
  assign respId         = respId_q;
  assign respResult     = respResult_q;
  assign respZero       = respZero_q;
  assign busy           = (state_q != IDLE);
  assign opCount        = opCount_q;

endmodule
